// File: rtl/wbus_sched_pkg.sv
// Shared types and constants for the write-bus transfer sequencer.
// Holds the sequencer state encoding and the phase-length helper.
package wbus_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic STROBE_OFF = 1'b1;

   // Last phase-counter value; HOLD_CYC is clamped to 1..15.
   function automatic logic [3:0] phase_last(input int hold);
      if (hold <= 1) return 4'd0;
      if (hold >= 15) return 4'd14;
      return 4'(hold - 1);
   endfunction

endpackage

// File: rtl/wbus_rr_arb.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping around; one-hot grant plus valid flag.
module wbus_rr_arb #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic            vld
);

   int j;

   always_comb begin
      gnt = '0;
      vld = 1'b0;
      j   = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!vld && req[j]) begin
            gnt[j] = 1'b1;
            vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wbus_xfer_sched.sv
// Write-bus transfer sequencer: round-robin grant, then CLR/RD/WR/DONE
// phases driving active-low strobes and latched register selects.
module wbus_xfer_sched
   import wbus_sched_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int SRC_W    = 4,
   parameter int DST_W    = 4,
   parameter int HOLD_CYC = 1
) (
   input  logic                  SIM_CLK,
   input  logic                  SIM_RST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*SRC_W-1:0] src,
   input  logic [NREQ*DST_W-1:0] dst,
   input  logic [NREQ-1:0]       clr_en,
   input  logic                  INHIBIT,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  CT_n,
   output logic                  RT_n,
   output logic                  WT_n,
   output logic [SRC_W-1:0]      RSEL,
   output logic [DST_W-1:0]      WSEL,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] PH_LAST = phase_last(HOLD_CYC);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [PW-1:0]     ptr_q, gidx, ptr_nx;
   logic [SRC_W-1:0]  src_q, src_d, src_pick;
   logic [DST_W-1:0]  dst_q, dst_d, dst_pick;
   logic              clr_pick;
   logic [NREQ-1:0]   arb_gnt, gnt_d;
   logic              arb_vld, take, ph_end;
   logic              rd_ph, wr_ph;

   wbus_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .vld (arb_vld)
   );

   always_comb begin
      gidx     = '0;
      src_pick = '0;
      dst_pick = '0;
      clr_pick = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            gidx     = PW'(i);
            src_pick = src[i*SRC_W +: SRC_W];
            dst_pick = dst[i*DST_W +: DST_W];
            clr_pick = clr_en[i];
         end
      end
   end

   assign ptr_nx = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
   assign take   = (state_q == IDLE) && !INHIBIT && arb_vld;
   assign ph_end = (cnt_q == PH_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         IDLE: if (take) state_d = clr_pick ? CLR : RD;
         CLR:  if (ph_end) state_d = RD;   else cnt_d = cnt_q + 4'd1;
         RD:   if (ph_end) state_d = WR;   else cnt_d = cnt_q + 4'd1;
         WR:   if (ph_end) state_d = DONE; else cnt_d = cnt_q + 4'd1;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   assign src_d = take ? src_pick : src_q;
   assign dst_d = take ? dst_pick : dst_q;
   assign gnt_d = take ? arb_gnt : gnt;
   assign rd_ph = (state_d == RD) || (state_d == WR);
   assign wr_ph = (state_d == CLR) || (state_d == WR);

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         gnt     <= '0;
         done    <= '0;
         CT_n    <= STROBE_OFF;
         RT_n    <= STROBE_OFF;
         WT_n    <= STROBE_OFF;
         RSEL    <= '0;
         WSEL    <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (take) ptr_q <= ptr_nx;
         src_q   <= src_d;
         dst_q   <= dst_d;
         gnt     <= (state_d == IDLE) ? '0 : gnt_d;
         done    <= (state_d == DONE) ? gnt_d : '0;
         CT_n    <= (state_d != CLR);
         RT_n    <= !rd_ph;
         WT_n    <= (state_d != WR);
         RSEL    <= rd_ph ? src_d : '0;
         WSEL    <= wr_ph ? dst_d : '0;
         busy    <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_wbus_xfer_sched.sv
// Directed bench for wbus_xfer_sched with a transfer scoreboard;
// a second instance covers HOLD_CYC=3.
module tb_wbus_xfer_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  req, clr_en;
   logic [11:0] src, dst;
   logic        inh;
   logic [2:0]  gnt, done;
   logic        ct_n, rt_n, wt_n, busy;
   logic [3:0]  rsel, wsel;

   logic [2:0]  req3, clr_en3;
   logic [11:0] src3, dst3;
   logic [2:0]  gnt3, done3;
   logic        ct_n3, rt_n3, wt_n3, busy3;
   logic [3:0]  rsel3, wsel3;

   wbus_xfer_sched #(.NREQ(3), .SRC_W(4), .DST_W(4), .HOLD_CYC(1)) dut (
      .SIM_CLK(clk), .SIM_RST(rst), .req(req), .src(src), .dst(dst),
      .clr_en(clr_en), .INHIBIT(inh), .gnt(gnt), .done(done),
      .CT_n(ct_n), .RT_n(rt_n), .WT_n(wt_n), .RSEL(rsel), .WSEL(wsel),
      .busy(busy)
   );

   wbus_xfer_sched #(.NREQ(3), .SRC_W(4), .DST_W(4), .HOLD_CYC(3)) dut3 (
      .SIM_CLK(clk), .SIM_RST(rst), .req(req3), .src(src3), .dst(dst3),
      .clr_en(clr_en3), .INHIBIT(1'b0), .gnt(gnt3), .done(done3),
      .CT_n(ct_n3), .RT_n(rt_n3), .WT_n(wt_n3), .RSEL(rsel3), .WSEL(wsel3),
      .busy(busy3)
   );

   typedef struct {
      int         idx;
      logic [3:0] s;
      logic [3:0] d;
      logic       clr;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] pk(
      logic ct, logic rt, logic wt, logic [3:0] rs, logic [3:0] ws,
      logic [2:0] g, logic [2:0] d, logic b);
      return {ct, rt, wt, rs, ws, g, d, b};
   endfunction

   task automatic chk(input string tag, input logic [17:0] obs,
                      input logic [17:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] obs1();
      return pk(ct_n, rt_n, wt_n, rsel, wsel, gnt, done, busy);
   endfunction

   function automatic logic [17:0] obs3();
      return pk(ct_n3, rt_n3, wt_n3, rsel3, wsel3, gnt3, done3, busy3);
   endfunction

   task automatic push(input int idx);
      exp_t e;
      e.idx = idx;
      e.s   = src[idx*4 +: 4];
      e.d   = dst[idx*4 +: 4];
      e.clr = clr_en[idx];
      sb.push_back(e);
   endtask

   // Call just before the edge that grants; returns at the idle cycle.
   task automatic follow(input string tag, input bit inh_in_rd);
      exp_t       e;
      logic [2:0] oh;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
         return;
      end
      e  = sb.pop_front();
      oh = 3'b001 << e.idx;
      if (e.clr) begin
         tick();
         chk({tag, "_clr"}, obs1(), pk(0, 1, 1, 0, e.d, oh, 0, 1));
      end
      tick();
      chk({tag, "_rd"}, obs1(), pk(1, 0, 1, e.s, 0, oh, 0, 1));
      if (inh_in_rd) inh = 1'b1;
      tick();
      chk({tag, "_wr"}, obs1(), pk(1, 0, 0, e.s, e.d, oh, 0, 1));
      tick();
      chk({tag, "_done"}, obs1(), pk(1, 1, 1, 0, 0, oh, oh, 1));
      tick();
      chk({tag, "_idle"}, obs1(), pk(1, 1, 1, 0, 0, 0, 0, 0));
   endtask

   initial begin
      rst = 1'b1; inh = 1'b0;
      req = '0; clr_en = '0; src = '0; dst = '0;
      req3 = '0; clr_en3 = '0; src3 = '0; dst3 = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset", obs1(), pk(1, 1, 1, 0, 0, 0, 0, 0));
      chk("reset3", obs3(), pk(1, 1, 1, 0, 0, 0, 0, 0));

      // single request with clear
      src[3:0] = 4'h5; dst[3:0] = 4'hA; clr_en = 3'b001; req = 3'b001;
      push(0);
      follow("t1", 0);
      req = '0;

      // no clear, requester 1
      src[7:4] = 4'h4; dst[7:4] = 4'hB; clr_en = 3'b000; req = 3'b010;
      push(1);
      follow("t2", 0);
      req = '0;

      // round robin from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      src = {4'h9, 4'h8, 4'h7};
      dst = {4'h3, 4'h2, 4'h1};
      clr_en = 3'b101;
      req = 3'b111;
      push(0); push(1); push(2); push(0);
      follow("rr0", 0);
      follow("rr1", 0);
      follow("rr2", 0);
      follow("rr3", 0);
      req = '0;

      // inhibit in idle holds off grants
      inh = 1'b1; req = 3'b100; clr_en = 3'b100;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("inh_idle", obs1(), pk(1, 1, 1, 0, 0, 0, 0, 0));
      end
      inh = 1'b0;
      push(2);
      follow("inh_rel", 0);
      push(2);
      follow("inh_rd", 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("inh_hold", obs1(), pk(1, 1, 1, 0, 0, 0, 0, 0));
      end
      inh = 1'b0; req = '0;
      tick();

      // reset during WR; aborted requester 1 would move pointer to 2
      src[7:4] = 4'hE; dst[7:4] = 4'h6; clr_en = 3'b000; req = 3'b010;
      tick();
      chk("abort_rd", obs1(), pk(1, 0, 1, 4'hE, 0, 3'b010, 0, 1));
      tick();
      chk("abort_wr", obs1(), pk(1, 0, 0, 4'hE, 4'h6, 3'b010, 0, 1));
      rst = 1'b1;
      tick();
      chk("abort_rst", obs1(), pk(1, 1, 1, 0, 0, 0, 0, 0));
      rst = 1'b0;
      req = 3'b110;
      push(1);
      follow("post_rst", 0);
      req = '0;

      // HOLD_CYC=3 instance
      src3[3:0] = 4'h3; dst3[3:0] = 4'hC; clr_en3 = 3'b001; req3 = 3'b001;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c <= 3)
            chk("h3_clr", obs3(), pk(0, 1, 1, 0, 4'hC, 3'b001, 0, 1));
         else if (c <= 6)
            chk("h3_rd", obs3(), pk(1, 0, 1, 4'h3, 0, 3'b001, 0, 1));
         else if (c <= 9)
            chk("h3_wr", obs3(), pk(1, 0, 0, 4'h3, 4'hC, 3'b001, 0, 1));
         else
            chk("h3_done", obs3(), pk(1, 1, 1, 0, 0, 3'b001, 3'b001, 1));
         if (c == 10) req3 = '0;
      end
      tick();
      chk("h3_idle", obs3(), pk(1, 1, 1, 0, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
